result_serializer: RTL and testbench
====================================

# result_serializer

Downstream stage of the `battleship` core. It captures each 12-bit result word presented with `data_ready` and buffers it in a small FIFO, so results are not lost while the link is busy. It then shifts each word off-chip on a single framed serial pin, which frees the 12 parallel result pins for board-level use.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥2.
- `BIT_DIV`, default 4: `ph1` cycles per serial bit. Must be ≥1.

Ports:
- `ph1` input 1: the block's single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `data_in` input 12: result word; connects to core `data_out`.
- `data_valid` input 1: connects to core `data_ready`. Level signal; one word per rising edge.
- `clr_ovf` input 1: synchronous clear of `overflow`.
- `ser_out` output 1: serial line, idle high.
- `busy` output 1: a frame is in progress.
- `pending` output $clog2(DEPTH+1): number of FIFO entries.
- `fifo_full` output 1: `pending == DEPTH`.
- `overflow` output 1: sticky flag; a word was dropped.

## Operation
- **Capture:** register `dv_q` holds the previous `data_valid`. A word is captured when `data_valid & ~dv_q`, and is written to the FIFO on that same edge. A level held high captures exactly once.
- **Full FIFO:** a capture while full and not popping that edge drops the word and sets `overflow`.
- **Capture and pop on the same edge:**
  - With a full FIFO, both happen; `pending` is unchanged and nothing is dropped.
  - With an empty FIFO, the word is written; it is not popped that edge.
- **Frame format:**
  - start bit 0
  - `data_in[0]` through `data_in[11]`, LSB first
  - even-parity bit (only when `RESULT_SER_PARITY_EN` is defined)
  - stop bit 1
  - Each bit lasts `BIT_DIV` cycles, counted by a bit-period counter that wraps at `BIT_DIV-1`.
- **FSM states:**
  - IDLE: `ser_out`=1, `busy`=0. If `pending`≠0, pop the head into the shift register and go to START.
  - START: after `BIT_DIV` cycles, go to DATA with bit index 0.
  - DATA: shift once per bit period. After index 11, go to PARITY if enabled, else STOP.
  - PARITY: one bit period, then STOP.
  - STOP: after `BIT_DIV` cycles, if `pending`≠0, pop and go directly to START (no idle gap); else go to IDLE.
- `busy` is 1 in every state except IDLE.
- **`overflow`:** cleared by `clr_ovf`. If a set and a clear occur on the same edge, the set wins.
- **Reset values:** `ser_out`=1, `busy`=0, `pending`=0, `fifo_full`=0, `overflow`=0, FSM=IDLE, FIFO pointers 0, `dv_q`=1.
  - Because `dv_q` resets to 1, a `data_valid` held high across reset release is not captured.
  - Reset asserted mid-frame forces `ser_out` high immediately and discards the frame and all FIFO contents.

## Timing
- Rising `data_valid` sampled at edge E0: `pending` becomes 1 after E0.
- At E1, IDLE pops the word; `ser_out` drives 0 and `busy` rises after E1.
- Frame length: 14×`BIT_DIV` cycles, or 15×`BIT_DIV` with parity.
- `ser_out` is driven from a register, so it is glitch-free.
- `fifo_full` and `pending` are registered and reflect the state after the current edge.
- `ser_out` returns to idle-high exactly at the end of STOP, unless back-to-back frames are pending.

## Configuration
- `RESULT_SER_PARITY_EN` defined: the PARITY state exists, and its bit equals the XOR of the 12 data bits.
- `RESULT_SER_PARITY_EN` undefined: DATA goes directly to STOP. The frame is 14 bits, and no parity logic is generated.

## Structure
- `battleship_pkg` holds:
  - `RESULT_W`=12
  - the `ser_state_t` enum (IDLE, START, DATA, PARITY, STOP)
  - bit-count constants (`DATA_BITS`=12)
- Sub-module `result_fifo` (parameters `DEPTH`, `RESULT_W`):
  - synchronous push/pop with simultaneous push and pop supported
  - pointers with a wrap bit
  - ports `count`, `full`, `empty`
- FSM, bit-period counter, shift register and edge detect all live in `result_serializer`.

## Test plan
- **Single word, `BIT_DIV`=4, no parity.** Stimulus: `data_in`=12'hA5C, one `data_valid` pulse. Required response: `ser_out` is 0 for 4 cycles, then data bits 0,0,1,1,1,0,1,0,0,1,0,1 for 4 cycles each, then 1. `busy` is high for exactly 56 cycles.
- **Parity build.** Stimulus: 12'hA5C, then 12'h001. Required response: parity bit 0 for 12'hA5C and 1 for 12'h001. Each frame is 60 cycles.
- **Held level.** Stimulus: `data_valid` high for 20 cycles. Required response: exactly one frame, and `pending` peaks at 1.
- **Overflow.** Stimulus: with `DEPTH`=4, 6 rising edges spaced 2 cycles apart during a frame. Required response:
  - the first word goes into the shift register and 4 are queued;
  - the sixth is dropped, and `overflow`=1 with `fifo_full`=1;
  - after `clr_ovf`, `overflow`=0;
  - five frames follow back-to-back with no idle cycles between them.
- **Reset mid-frame.** Stimulus: assert `reset` at bit 5 of a frame while 2 words are queued. Required response: `ser_out`=1 and `pending`=0 immediately, and no frame after release while `data_valid` stays high.
- **Simultaneous events.**
  - Stimulus: capture on the same edge that STOP pops from a full FIFO. Required response: no drop, `pending` stays at `DEPTH`.
  - Stimulus: `clr_ovf` on the same edge as a drop. Required response: `overflow` stays 1.

Source files
------------

// File: rtl/battleship_pkg.sv
// battleship_pkg: shared widths, bit counts and serializer state encoding
// for the downstream result path of the battleship core.
// Optional feature macro used by the serializer: RESULT_SER_PARITY_EN.
package battleship_pkg;

    // Width of one result word coming out of the core
    localparam int RESULT_W  = 12;

    // Number of data bits carried in one serial frame
    localparam int DATA_BITS = 12;

    // Serial framer states; PARITY is only reachable in parity builds
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } ser_state_t;

endpackage

// File: rtl/result_fifo.sv
// result_fifo: small power-of-two FIFO holding captured result words.
// Pointers carry an extra wrap bit so full and empty are told apart
// without a separate counter. A push into a full FIFO is accepted only
// when a pop happens on the same edge.
module result_fifo #(
    parameter int DEPTH    = 4,
    parameter int RESULT_W = 12
) (
    input  logic                         ph1,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [RESULT_W-1:0]          wdata,
    output logic [RESULT_W-1:0]          rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [RESULT_W-1:0] mem_q [DEPTH];
    logic [AW:0]         wrPtr_q, wrPtr_d;
    logic [AW:0]         rdPtr_q, rdPtr_d;
    logic                doPush, doPop;

    assign empty  = (wrPtr_q == rdPtr_q);
    assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                    (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign count  = CW'(wrPtr_q - rdPtr_q);
    assign rdata  = mem_q[rdPtr_q[AW-1:0]];
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);

    // Advance each pointer when its side of the FIFO actually moves
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) wrPtr_d = wrPtr_q + 1'b1;
        if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage array; contents are don't-care until the pointers cover them
    always_ff @(posedge ph1) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/result_serializer.sv
// result_serializer: captures result words on the rising edge of
// data_valid, buffers them in result_fifo and sends each one as a framed
// serial word: start 0, 12 data bits LSB first, optional even parity,
// stop 1, each bit BIT_DIV clocks long.
// Optional feature macro: RESULT_SER_PARITY_EN adds the parity bit.
module result_serializer
    import battleship_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int BIT_DIV = 4
) (
    input  logic                         ph1,
    input  logic                         reset,
    input  logic [RESULT_W-1:0]          data_in,
    input  logic                         data_valid,
    input  logic                         clr_ovf,
    output logic                         ser_out,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         fifo_full,
    output logic                         overflow
);

    localparam int               CNT_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    ser_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [RESULT_W-1:0] shift_q, shift_d;
    logic                ser_q, ser_d;
    logic                dv_q;
    logic                ovf_q, ovf_d;
    logic                capture;
    logic                pop;
    logic                bitDone;
    logic                fifoEmpty;
    logic [RESULT_W-1:0] fifoHead;
`ifdef RESULT_SER_PARITY_EN
    logic                parity_q, parity_d;
`endif

    assign capture  = data_valid & ~dv_q;
    assign bitDone  = (cnt_q == CNT_LAST);
    assign ser_out  = ser_q;
    assign busy     = (state_q != IDLE);
    assign overflow = ovf_q;

    result_fifo #(
        .DEPTH    (DEPTH),
        .RESULT_W (RESULT_W)
    ) u_fifo (
        .ph1   (ph1),
        .reset (reset),
        .push  (capture),
        .pop   (pop),
        .wdata (data_in),
        .rdata (fifoHead),
        .count (pending),
        .full  (fifo_full),
        .empty (fifoEmpty)
    );

    // Drop-detect sets overflow; a set on the same edge as a clear wins
    always_comb begin
        ovf_d = ovf_q;
        if (capture && fifo_full && !pop) ovf_d = 1'b1;
        else if (clr_ovf)                 ovf_d = 1'b0;
    end

    // Framer next state: bit timing, shifting, popping and line level
    always_comb begin
        state_d  = state_q;
        cnt_d    = bitDone ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        ser_d    = ser_q;
        pop      = 1'b0;
`ifdef RESULT_SER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                ser_d = 1'b1;
                if (!fifoEmpty) begin
                    pop      = 1'b1;
                    shift_d  = fifoHead;
`ifdef RESULT_SER_PARITY_EN
                    parity_d = ^fifoHead;
`endif
                    ser_d    = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (bitDone) begin
                    idx_d   = '0;
                    ser_d   = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bitDone) begin
                    if (idx_q == IDX_LAST) begin
`ifdef RESULT_SER_PARITY_EN
                        ser_d   = parity_q;
                        state_d = PARITY;
`else
                        ser_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        ser_d   = shift_q[1];
                    end
                end
            end
`ifdef RESULT_SER_PARITY_EN
            PARITY: begin
                if (bitDone) begin
                    ser_d   = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bitDone) begin
                    if (!fifoEmpty) begin
                        pop      = 1'b1;
                        shift_d  = fifoHead;
`ifdef RESULT_SER_PARITY_EN
                        parity_d = ^fifoHead;
`endif
                        ser_d    = 1'b0;
                        state_d  = START;
                    end else begin
                        ser_d    = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                ser_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Framer, edge-detect and overflow registers; reset idles the line high
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            ser_q    <= 1'b1;
            dv_q     <= 1'b1;
            ovf_q    <= 1'b0;
`ifdef RESULT_SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            ser_q    <= ser_d;
            dv_q     <= data_valid;
            ovf_q    <= ovf_d;
`ifdef RESULT_SER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: directed bench for result_serializer with
// DEPTH=4 and BIT_DIV=4. Frame expectations follow RESULT_SER_PARITY_EN.
module tb_result_serializer;

    localparam int DEPTH   = 4;
    localparam int BIT_DIV = 4;
`ifdef RESULT_SER_PARITY_EN
    localparam int FRAME_BITS = 15;
`else
    localparam int FRAME_BITS = 14;
`endif
    localparam int FRAME_CYC = FRAME_BITS * BIT_DIV;

    logic        ph1;
    logic        reset;
    logic [11:0] data_in;
    logic        data_valid;
    logic        clr_ovf;
    logic        ser_out;
    logic        busy;
    logic [2:0]  pending;
    logic        fifo_full;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    int peak     = 0;
    bit trackPeak = 0;

    logic [11:0] ovfWords [7] = '{12'h111, 12'h222, 12'h333, 12'h444,
                                  12'h555, 12'h666, 12'h777};

    result_serializer #(
        .DEPTH   (DEPTH),
        .BIT_DIV (BIT_DIV)
    ) dut (
        .ph1        (ph1),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clr_ovf    (clr_ovf),
        .ser_out    (ser_out),
        .busy       (busy),
        .pending    (pending),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    // Free-running clock
    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    // Record the largest pending value seen while tracking is enabled
    always @(negedge ph1) begin
        if (trackPeak && int'(pending) > peak) peak = int'(pending);
    end

    // Hard stop in case something goes badly wrong
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] w, input logic dv, input logic clr);
        data_in    = w;
        data_valid = dv;
        clr_ovf    = clr;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ph1);
    endtask

    // Expected line level for frame bit k of word w
    function automatic logic frameBit(input logic [11:0] w, input int k);
        if (k == 0)  return 1'b0;
        if (k <= 12) return w[k-1];
`ifdef RESULT_SER_PARITY_EN
        if (k == 13) return ^w;
`endif
        return 1'b1;
    endfunction

    // Called at cycle 0 of a frame; checks every cycle and what follows
    task automatic checkFrame(input logic [11:0] w, input bit idleAfter, input string tag);
        for (int c = 0; c < FRAME_CYC; c++) begin
            checkOutput($sformatf("%s_ser_c%0d", tag, c), ser_out, frameBit(w, c / BIT_DIV));
            checkOutput($sformatf("%s_busy_c%0d", tag, c), busy, 1);
            tick(1);
        end
        if (idleAfter) begin
            checkOutput({tag, "_end_busy"}, busy, 0);
            checkOutput({tag, "_end_ser"}, ser_out, 1);
        end else begin
            checkOutput({tag, "_b2b_busy"}, busy, 1);
            checkOutput({tag, "_b2b_ser"}, ser_out, 0);
        end
    endtask

    // One isolated word: capture, pop on the next edge, full frame
    task automatic singleFrame(input logic [11:0] w, input string tag);
        applyStimulus(w, 1'b1, 1'b0);
        tick(1);
        applyStimulus(w, 1'b0, 1'b0);
        checkOutput({tag, "_pending_after_capture"}, pending, 1);
        checkOutput({tag, "_busy_before_pop"}, busy, 0);
        tick(1);
        checkOutput({tag, "_pending_after_pop"}, pending, 0);
        checkFrame(w, 1'b1, tag);
        tick(2);
    endtask

    initial begin
        int busyCnt;

        reset = 1'b0;
        applyStimulus(12'h000, 1'b0, 1'b0);
        tick(1);
        checkOutput("rst_ser", ser_out, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pending", pending, 0);
        checkOutput("rst_full", fifo_full, 0);
        checkOutput("rst_ovf", overflow, 0);
        reset = 1'b1;
        tick(2);

        singleFrame(12'hA5C, "a5c");
        singleFrame(12'h001, "w001");

        // Held level: one capture only, pending never exceeds 1
        peak = 0;
        trackPeak = 1;
        applyStimulus(12'h3C3, 1'b1, 1'b0);
        tick(2);
        checkFrame(12'h3C3, 1'b1, "held");
        busyCnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busyCnt++;
            tick(1);
        end
        checkOutput("held_no_second_frame", busyCnt, 0);
        checkOutput("held_pending", pending, 0);
        checkOutput("held_peak", peak, 1);
        trackPeak = 0;
        applyStimulus(12'h000, 1'b0, 1'b0);
        tick(2);

        // Overflow: six rising edges two cycles apart during a frame
        applyStimulus(ovfWords[0], 1'b1, 1'b0);
        tick(1);
        applyStimulus(ovfWords[0], 1'b0, 1'b0);
        tick(1);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(ovfWords[i], 1'b1, (i == 5));
            tick(1);
            applyStimulus(ovfWords[i], 1'b0, 1'b0);
            tick(1);
        end
        checkOutput("ovf_set_wins", overflow, 1);
        checkOutput("ovf_full", fifo_full, 1);
        checkOutput("ovf_pending", pending, 4);
        applyStimulus(12'h000, 1'b0, 1'b1);
        tick(1);
        applyStimulus(12'h000, 1'b0, 1'b0);
        checkOutput("ovf_cleared", overflow, 0);
        tick(FRAME_CYC - 1 - 11);
        checkOutput("ovf_stop_ser", ser_out, 1);
        checkOutput("ovf_stop_full", fifo_full, 1);
        applyStimulus(ovfWords[6], 1'b1, 1'b0);
        tick(1);
        applyStimulus(ovfWords[6], 1'b0, 1'b0);
        checkOutput("simul_pending", pending, 4);
        checkOutput("simul_no_drop", overflow, 0);
        checkFrame(ovfWords[1], 1'b0, "q1");
        checkFrame(ovfWords[2], 1'b0, "q2");
        checkFrame(ovfWords[3], 1'b0, "q3");
        checkFrame(ovfWords[4], 1'b0, "q4");
        checkFrame(ovfWords[6], 1'b1, "q6");
        tick(2);

        // Reset mid-frame with two words queued and data_valid held high
        applyStimulus(12'h0E0, 1'b1, 1'b0);
        tick(1);
        applyStimulus(12'h0E0, 1'b0, 1'b0);
        tick(1);
        for (int i = 1; i <= 2; i++) begin
            applyStimulus(ovfWords[i], 1'b1, 1'b0);
            tick(1);
            applyStimulus(ovfWords[i], 1'b0, 1'b0);
            tick(1);
        end
        checkOutput("mid_pending", pending, 2);
        tick(17);
        checkOutput("mid_ser_bit5", ser_out, 0);
        applyStimulus(12'hFFF, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_ser", ser_out, 1);
        checkOutput("mid_rst_pending", pending, 0);
        checkOutput("mid_rst_busy", busy, 0);
        tick(2);
        reset = 1'b1;
        busyCnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (busy) busyCnt++;
            tick(1);
        end
        checkOutput("mid_no_frame", busyCnt, 0);
        checkOutput("mid_pending_after", pending, 0);
        applyStimulus(12'h000, 1'b0, 1'b0);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
